// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported byte-writable synchronous memory
// between instruction fetch (I) and load/store (D); D has priority, bounded by an I starvation counter.
module mem_arbiter #(
  parameter int MAX_IWAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic        mem_ready,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int IW = $clog2(MAX_IWAIT + 1);
  localparam logic [IW-1:0] IWAIT_MAX = IW'(MAX_IWAIT);

  // Handshake: a request is accepted in the cycle where req and gnt are both
  // high; the requester holds its address/data stable until then.

  logic [IW-1:0] iwait, iwait_nxt;
  logic          rd_pending, rd_owner;
  logic          i_starved;

  assign i_starved = (iwait == IWAIT_MAX);

  // Grants are gated by rst_n so nothing is issued while reset is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n && mem_ready) begin
      if (i_req && (!d_req || i_starved)) i_gnt = 1'b1;
      else if (d_req)                     d_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_addr  = 32'h0;
    mem_we    = 4'h0;
    mem_wdata = 32'h0;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end
  end

  // Denied cycles count even when the memory is not ready.
  always_comb begin
    iwait_nxt = '0;
    if (i_req && !i_gnt) iwait_nxt = i_starved ? iwait : iwait + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iwait      <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      iwait      <= iwait_nxt;
      rd_pending <= i_gnt | (d_gnt && (d_we == 4'h0));
      rd_owner   <= d_gnt;
    end
  end

  assign i_rvalid = rd_pending & ~rd_owner;
  assign d_rvalid = rd_pending & rd_owner;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single-access cases plus
// hand-written sequences for reset, starvation, back-to-back and stall behaviour.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_ready;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mem_arbiter #(.MAX_IWAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        mem_ready;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        e_i_gnt;
    logic        e_d_gnt;
    logic        e_en;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic        e_i_rvalid;
    logic        e_d_rvalid;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_req   = 1'b0;
    d_req   = 1'b0;
    i_addr  = 32'h0;
    d_addr  = 32'h0;
    d_we    = 4'h0;
    d_wdata = 32'h0;
  endtask

  initial begin
    vecs[0] = '{1, 0, 1, 32'h100, 32'h0,   4'h0, 32'h0,      1, 0, 1, 32'h100, 4'h0, 32'h0,      1, 0};
    vecs[1] = '{0, 1, 1, 32'h0,   32'h40,  4'hF, 32'h12345678, 0, 1, 1, 32'h40,  4'hF, 32'h12345678, 0, 0};
    vecs[2] = '{0, 1, 1, 32'h0,   32'h80,  4'h0, 32'h0,      0, 1, 1, 32'h80,  4'h0, 32'h0,      0, 1};
    vecs[3] = '{1, 1, 1, 32'h300, 32'h200, 4'h0, 32'h0,      0, 1, 1, 32'h200, 4'h0, 32'h0,      0, 1};
    vecs[4] = '{1, 1, 0, 32'h300, 32'h200, 4'h0, 32'h0,      0, 0, 0, 32'h0,   4'h0, 32'h0,      0, 0};
    vecs[5] = '{0, 0, 1, 32'h500, 32'h600, 4'h5, 32'h77,     0, 0, 0, 32'h0,   4'h0, 32'h0,      0, 0};
    vecs[6] = '{0, 1, 1, 32'h0,   32'h44,  4'h3, 32'hA5A5,   0, 1, 1, 32'h44,  4'h3, 32'hA5A5,   0, 0};
    vecs[7] = '{1, 1, 1, 32'h8,   32'h4C,  4'h1, 32'hFF,     0, 1, 1, 32'h4C,  4'h1, 32'hFF,     0, 0};

    // Reset held with both ports requesting
    rst_n = 1'b0;
    drive_idle();
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE0000;
    @(negedge clk);
    check("rst_i_gnt", 32'(i_gnt), 32'h0);
    check("rst_d_gnt", 32'(d_gnt), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    check("rst_rdata_follow", i_rdata, 32'hCAFE0000);

    // Release: D first, then starvation pattern D,D,D,D,I repeating
    after_edge();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("starve_i_gnt_%0d", k), 32'(i_gnt), (k % 5 == 4) ? 32'h1 : 32'h0);
      check($sformatf("starve_d_gnt_%0d", k), 32'(d_gnt), (k % 5 == 4) ? 32'h0 : 32'h1);
      check($sformatf("starve_addr_%0d", k), mem_addr, (k % 5 == 4) ? 32'h10 : 32'h20);
      after_edge();
    end

    // Back-to-back loads with a return overlapping the next grant
    drive_idle();
    d_req = 1'b1; d_addr = 32'h0;
    @(negedge clk);
    check("b2b_gnt0", 32'(d_gnt), 32'h1);
    after_edge();
    d_addr = 32'h4; mem_rdata = 32'h11111111;
    @(negedge clk);
    check("b2b_gnt1", 32'(d_gnt), 32'h1);
    check("b2b_addr1", mem_addr, 32'h4);
    check("b2b_rvalid0", 32'(d_rvalid), 32'h1);
    check("b2b_rdata0", d_rdata, 32'h11111111);
    after_edge();
    d_req = 1'b0; mem_rdata = 32'h22222222;
    @(negedge clk);
    check("b2b_rvalid1", 32'(d_rvalid), 32'h1);
    check("b2b_rdata1", d_rdata, 32'h22222222);
    check("b2b_i_rvalid", 32'(i_rvalid), 32'h0);
    after_edge();
    @(negedge clk);
    check("b2b_rvalid_end", 32'(d_rvalid), 32'h0);

    // Memory stalled while I requests: iwait climbs to 3, D still wins, then I
    after_edge();
    i_req = 1'b1; i_addr = 32'h900; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_en_%0d", k), 32'(mem_en), 32'h0);
      check($sformatf("stall_gnt_%0d", k), {30'h0, i_gnt, d_gnt}, 32'h0);
      after_edge();
    end
    mem_ready = 1'b1; d_req = 1'b1; d_addr = 32'h60;
    @(negedge clk);
    check("stall_d_wins", {30'h0, i_gnt, d_gnt}, 32'h1);
    after_edge();
    @(negedge clk);
    check("stall_i_wins", {30'h0, i_gnt, d_gnt}, 32'h2);
    check("stall_i_addr", mem_addr, 32'h900);
    after_edge();
    // Return still arrives while the memory is not ready
    drive_idle();
    mem_ready = 1'b0; mem_rdata = 32'h33333333;
    @(negedge clk);
    check("stall_ret_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h2);
    check("stall_ret_rdata", i_rdata, 32'h33333333);
    check("stall_ret_en", 32'(mem_en), 32'h0);

    // Reset in the cycle after a load grant suppresses the return
    after_edge();
    mem_ready = 1'b1; d_req = 1'b1; d_addr = 32'h70;
    @(negedge clk);
    check("rstrd_gnt", 32'(d_gnt), 32'h1);
    after_edge();
    rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("rstrd_rvalid", 32'(d_rvalid), 32'h0);
    after_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstrd_no_replay", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    after_edge();

    // Table of single accesses, each followed by an idle return cycle
    for (int v = 0; v < 8; v++) begin
      i_req = vecs[v].i_req; d_req = vecs[v].d_req; mem_ready = vecs[v].mem_ready;
      i_addr = vecs[v].i_addr; d_addr = vecs[v].d_addr;
      d_we = vecs[v].d_we; d_wdata = vecs[v].d_wdata;
      @(negedge clk);
      check($sformatf("v%0d_i_gnt", v), 32'(i_gnt), 32'(vecs[v].e_i_gnt));
      check($sformatf("v%0d_d_gnt", v), 32'(d_gnt), 32'(vecs[v].e_d_gnt));
      check($sformatf("v%0d_en", v), 32'(mem_en), 32'(vecs[v].e_en));
      check($sformatf("v%0d_addr", v), mem_addr, vecs[v].e_addr);
      check($sformatf("v%0d_we", v), 32'(mem_we), 32'(vecs[v].e_we));
      check($sformatf("v%0d_wdata", v), mem_wdata, vecs[v].e_wdata);
      after_edge();
      drive_idle();
      mem_ready = 1'b1;
      mem_rdata = $urandom_range(32'h7FFF_FFFF, 1);
      if (vecs[v].e_i_rvalid || vecs[v].e_d_rvalid) exp_q.push_back(mem_rdata);
      @(negedge clk);
      check($sformatf("v%0d_i_rvalid", v), 32'(i_rvalid), 32'(vecs[v].e_i_rvalid));
      check($sformatf("v%0d_d_rvalid", v), 32'(d_rvalid), 32'(vecs[v].e_d_rvalid));
      if (i_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_unexpected_return", v), 32'h1, 32'h0);
        end else begin
          logic [31:0] exp_data;
          exp_data = exp_q.pop_front();
          check($sformatf("v%0d_rdata", v), i_rvalid ? i_rdata : d_rdata, exp_data);
        end
      end
      after_edge();
    end
    check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
